// File: rtl/input_confirm_ctrl_if.sv
// CPU IO-load bus for the switch/confirm window.
// The master (CPU side) drives the load strobe and address.
// The slave (input_confirm_ctrl) returns registered read data.
interface input_confirm_ctrl_if;
  logic        io_read;
  logic [31:0] address;
  logic [15:0] rdata;

  modport master (
    output io_read,
    output address,
    input  rdata
  );

  modport slave (
    input  io_read,
    input  address,
    output rdata
  );
endinterface

// File: rtl/input_confirm_ctrl.sv
// input_confirm_ctrl: confirm push-button front end for the CPU IO window.
// The raw button is synchronized, optionally debounced, and each accepted
// press captures the DIP switches into a snapshot register. The CPU reads
// the snapshot and a status word {overrun, confirm_pending} through the
// IO-load bus. A status read clears pending/overrun.
// All state updates on the falling edge of clk, in line with the IO read path.
//
// Build option: define INPUT_CONFIRM_DEBOUNCE_EN to enable the debounce
// counter (PRESS_WAIT / RELEASE_WAIT states). When it is left undefined,
// a press is accepted as soon as the synchronized button is seen high.
module input_confirm_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 200000
) (
  input  logic                 clk,
  input  logic                 rst,
  input_confirm_ctrl_if.slave  bus,
  input  logic [15:0]          switch_input,
  input  logic                 confirm_btn,
  output logic                 confirm_pending,
  output logic                 confirm_pulse
);

  // Read map
  localparam logic [31:0] ADDR_STATUS = 32'hFFFF_FF00;
  localparam logic [31:0] ADDR_SNAP   = 32'hFFFF_FFF1;
  localparam logic [31:0] ADDR_HI_SX  = 32'hFFFF_FFF3;
  localparam logic [31:0] ADDR_HI_ZX  = 32'hFFFF_FFF5;
  localparam logic [31:0] ADDR_LO3    = 32'hFFFF_FFF7;
  localparam logic [31:0] ADDR_LO8    = 32'hFFFF_FFF9;

  // A count outside 2 .. 2^20-1 cannot be represented by the 20-bit counter
  if ((DEBOUNCE_CYCLES < 2) || (DEBOUNCE_CYCLES > 1048575)) begin : g_bad_debounce_cycles
    $error("input_confirm_ctrl: DEBOUNCE_CYCLES out of range");
  end

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_PRESS_WAIT   = 2'd1,
    ST_HELD         = 2'd2,
    ST_RELEASE_WAIT = 2'd3
  } state_t;

  state_t      r_state;
  logic        r_sync1;
  logic        r_sync2;
  logic [15:0] r_snap;
  logic        r_pending;
  logic        r_overrun;
  logic        r_pulse;
  logic [15:0] r_rdata;

  logic        w_accept;
  logic        w_status_clr;

`ifdef INPUT_CONFIRM_DEBOUNCE_EN
  // The state entry edge already saw one high/low sample, so the counter
  // only has to climb to DEBOUNCE_CYCLES-2 before the next edge makes it
  // DEBOUNCE_CYCLES stable samples in total.
  localparam logic [19:0] P_CNT_LAST = 20'(DEBOUNCE_CYCLES - 2);
  logic [19:0] r_cnt;
`endif

  // Read-data mux: formed from the register values present before the edge
  function automatic logic [15:0] read_mux(
    input logic [31:0] addr,
    input logic [15:0] snap,
    input logic        pend,
    input logic        ovr
  );
    logic [15:0] v;
    case (addr)
      ADDR_STATUS: v = {14'd0, ovr, pend};
      ADDR_SNAP:   v = snap;
      ADDR_HI_SX:  v = {{8{snap[15]}}, snap[15:8]};
      ADDR_HI_ZX:  v = {8'd0, snap[15:8]};
      ADDR_LO3:    v = {13'd0, snap[2:0]};
      ADDR_LO8:    v = {8'd0, snap[7:0]};
      default:     v = 16'd0;
    endcase
    return v;
  endfunction

  assign w_status_clr = bus.io_read && (bus.address == ADDR_STATUS);

  // Two-flop synchronizer for the asynchronous confirm button
  always_ff @(negedge clk) begin
    if (!rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= confirm_btn;
      r_sync2 <= r_sync1;
    end
  end

  // Accepted-press condition: the edge on which the FSM enters HELD from the press side
  always_comb begin
    w_accept = 1'b0;
`ifdef INPUT_CONFIRM_DEBOUNCE_EN
    if ((r_state == ST_PRESS_WAIT) && r_sync2 && (r_cnt == P_CNT_LAST)) begin
      w_accept = 1'b1;
    end else begin
      w_accept = 1'b0;
    end
`else
    if ((r_state == ST_IDLE) && r_sync2) begin
      w_accept = 1'b1;
    end else begin
      w_accept = 1'b0;
    end
`endif
  end

`ifdef INPUT_CONFIRM_DEBOUNCE_EN
  // Debounce FSM with a saturating stable-sample counter, cleared on every state change
  always_ff @(negedge clk) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= 20'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_cnt <= 20'd0;
          if (r_sync2) begin
            r_state <= ST_PRESS_WAIT;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_PRESS_WAIT: begin
          if (!r_sync2) begin
            r_state <= ST_IDLE;
            r_cnt   <= 20'd0;
          end else if (r_cnt == P_CNT_LAST) begin
            r_state <= ST_HELD;
            r_cnt   <= 20'd0;
          end else begin
            r_state <= ST_PRESS_WAIT;
            r_cnt   <= r_cnt + 20'd1;
          end
        end
        ST_HELD: begin
          r_cnt <= 20'd0;
          if (!r_sync2) begin
            r_state <= ST_RELEASE_WAIT;
          end else begin
            r_state <= ST_HELD;
          end
        end
        ST_RELEASE_WAIT: begin
          if (r_sync2) begin
            r_state <= ST_HELD;
            r_cnt   <= 20'd0;
          end else if (r_cnt == P_CNT_LAST) begin
            r_state <= ST_IDLE;
            r_cnt   <= 20'd0;
          end else begin
            r_state <= ST_RELEASE_WAIT;
            r_cnt   <= r_cnt + 20'd1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= 20'd0;
        end
      endcase
    end
  end
`else
  // Two-state press tracker: the wait states are never entered without debouncing
  always_ff @(negedge clk) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (r_sync2) begin
            r_state <= ST_HELD;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_HELD: begin
          if (!r_sync2) begin
            r_state <= ST_IDLE;
          end else begin
            r_state <= ST_HELD;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end
`endif

  // Press capture and status: a set from an accepted press wins over a status-read clear
  always_ff @(negedge clk) begin
    if (!rst) begin
      r_pulse   <= 1'b0;
      r_snap    <= 16'd0;
      r_pending <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_pulse <= w_accept;
      if (w_accept) begin
        r_snap    <= switch_input;
        r_pending <= 1'b1;
        // Overrun is judged against the pending flag as it stood before any clear
        r_overrun <= (w_status_clr ? 1'b0 : r_overrun) | r_pending;
      end else if (w_status_clr) begin
        r_pending <= 1'b0;
        r_overrun <= 1'b0;
      end else begin
        r_pending <= r_pending;
        r_overrun <= r_overrun;
      end
    end
  end

  // Read data register: loaded on an IO load strobe, held otherwise
  always_ff @(negedge clk) begin
    if (!rst) begin
      r_rdata <= 16'd0;
    end else if (bus.io_read) begin
      r_rdata <= read_mux(bus.address, r_snap, r_pending, r_overrun);
    end else begin
      r_rdata <= r_rdata;
    end
  end

  assign bus.rdata       = r_rdata;
  assign confirm_pending = r_pending;
  assign confirm_pulse   = r_pulse;

endmodule

// File: doc/input_confirm_ctrl.md
INPUT_CONFIRM_CTRL -- requirements
Module: input_confirm_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset; all state SHALL update on the falling edge of clk, matching the IO read path timing.
REQ-002 Parameter DEBOUNCE_CYCLES, default 200000, is the number of stable cycles required to accept a button level change; legal range is 2 to 2^20-1.
REQ-003 Port clk, input, 1 bit: system clock.
REQ-004 Port rst, input, 1 bit: synchronous reset, active low.
REQ-005 Port io_read, input, 1 bit: CPU IO load strobe, high when the switch/confirm address window is selected.
REQ-006 Port address, input, 32 bits: CPU IO load address.
REQ-007 Port switch_input, input, 16 bits: raw board DIP switches, asynchronous.
REQ-008 Port confirm_btn, input, 1 bit: raw confirm push-button, active high, asynchronous.
REQ-009 Port rdata, output, 16 bits: registered read data returned to the CPU.
REQ-010 Port confirm_pending, output, 1 bit: a confirmed snapshot is waiting to be read.
REQ-011 Port confirm_pulse, output, 1 bit: one-cycle strobe on each accepted press.

Function
REQ-012 confirm_btn SHALL pass through a 2-flop synchronizer before any other use.
REQ-013 The debounce FSM SHALL have four states: IDLE, PRESS_WAIT, HELD and RELEASE_WAIT.
REQ-014 IDLE SHALL go to PRESS_WAIT when the synchronized button is 1.
REQ-015 PRESS_WAIT SHALL count while the button is 1, go to HELD when the count reaches DEBOUNCE_CYCLES-1, and return to IDLE with the count cleared if the button is 0.
REQ-016 HELD SHALL go to RELEASE_WAIT when the button is 0.
REQ-017 RELEASE_WAIT SHALL count while the button is 0, go to IDLE at DEBOUNCE_CYCLES-1, and return to HELD with the count cleared if the button is 1.
REQ-018 On the PRESS_WAIT to HELD transition, the block SHALL, in the same edge: assert confirm_pulse for exactly one cycle, capture switch_input into a 16-bit snapshot register, and set confirm_pending.
REQ-019 An accepted press while confirm_pending=1 SHALL overwrite the snapshot, set the sticky overrun bit, and leave confirm_pending at 1.
REQ-020 Read map, sampled when io_read=1: 0xFFFF_FF00 returns {14'b0, overrun, confirm_pending}.
REQ-021 Address 0xFFFF_FFF1 SHALL return snap[15:0].
REQ-022 Address 0xFFFF_FFF3 SHALL return snap[15:8] sign-extended to 16 bits.
REQ-023 Address 0xFFFF_FFF5 SHALL return snap[15:8] zero-extended to 16 bits.
REQ-024 Address 0xFFFF_FFF7 SHALL return snap[2:0] zero-extended to 16 bits.
REQ-025 Address 0xFFFF_FFF9 SHALL return snap[7:0] zero-extended to 16 bits.
REQ-026 Any other address SHALL return 0.
REQ-027 rdata SHALL be loaded on the edge where io_read=1 and SHALL hold its value while io_read=0.
REQ-028 A read of 0xFFFF_FF00 SHALL clear confirm_pending and overrun on the same edge, after the returned value has been formed.
REQ-029 If a clear and an accepted press occur on the same edge, set SHALL win: confirm_pending=1, and overrun SHALL follow REQ-019 using the pre-clear pending value.
REQ-030 The snapshot SHALL change only on an accepted press; live switch movement SHALL never alter rdata.
REQ-031 The debounce counter SHALL be no wider than 20 bits and SHALL never wrap; it is cleared on every state change.

Reset
REQ-032 When rst=0 at a falling edge: FSM=IDLE, counter=0, synchronizer=0, snapshot=0, confirm_pending=0, overrun=0, confirm_pulse=0, rdata=0.
REQ-033 Reset mid-debounce SHALL discard the partial count and SHALL produce no pulse.
REQ-034 A button held through reset release SHALL be treated as a new press and debounced from zero.

Configuration
REQ-035 Macro INPUT_CONFIRM_DEBOUNCE_EN controls debouncing.
REQ-036 When the macro is defined, REQ-013 to REQ-017 SHALL apply.
REQ-037 When the macro is undefined, PRESS_WAIT and RELEASE_WAIT SHALL be unreachable: IDLE goes to HELD when the synchronized button is 1, HELD goes to IDLE when it is 0, and the counter SHALL be omitted. A press is then accepted 3 edges after the pin rises.

Verification
REQ-038 DEBOUNCE_CYCLES=4, switches=0xA5C3, button held 10 cycles -> exactly one confirm_pulse; read 0xFFFF_FFF1 -> 0xA5C3; read 0xFFFF_FF00 -> 0x0001, then -> 0x0000.
REQ-039 Button glitches of 1, 2 and 3 cycles with DEBOUNCE_CYCLES=4 -> no pulse, confirm_pending stays 0.
REQ-040 Snapshot 0x8F07 -> 0xFFF3 returns 0xFF8F, 0xFFF5 returns 0x008F, 0xFFF7 returns 0x0007, 0xFFF9 returns 0x0007, 0x1234 returns 0x0000.
REQ-041 Two accepted presses with no status read -> status reads 0x0003 and the snapshot equals the second press's switches.
REQ-042 Status read on the same edge as an accepted press -> returns the old value, and confirm_pending=1 afterwards.
REQ-043 rst=0 asserted during PRESS_WAIT, button held across release -> no pulse during reset; one pulse DEBOUNCE_CYCLES+2 edges after release.
